// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches one instruction from execute, runs up to two
// data-memory beats with a per-beat ack timeout, then holds the results for writeback.
module mem_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] Addr_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] LMD,
  output logic [WIDTH-1:0] LMD_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             IsStall,
  output logic             mem_err
);
  // Opcode lives in IR[WIDTH-1 -: 6]; values mirror the ISA opcode table.
  localparam logic [5:0] OP_LH = 6'h21;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_LD = 6'h37;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_SD = 6'h3F;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SD);
  endfunction

  function automatic logic is_two(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

  function automatic logic is_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_SH);
  endfunction

  function automatic logic [WIDTH-1:0] half_sext(input logic [WIDTH-1:0] d, input logic hi);
    logic signed [15:0] h;
    h = hi ? d[31:16] : d[15:0];
    return {{(WIDTH-16){h[15]}}, h};
  endfunction

  state_t           state, state_nxt;
  logic             beat, beat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             take;
  logic [WIDTH-1:0] ir_p1, z_p1, addr_p1, lmd_p1, lmd_hi_p1;
  logic [WIDTH-1:0] lmd_nxt, lmd_hi_nxt;
  logic [WIDTH-3:0] pc_p1;
  logic [5:0]       op, op_in;
  logic [WIDTH-1:0] word_addr;
  logic             unused_addr_bit;

  assign op              = ir_p1[WIDTH-1 -: 6];
  assign op_in           = IR_in[WIDTH-1 -: 6];
  assign in_ready        = (state == IDLE) || ((state == HOLD) && out_ready);
  assign IsStall         = in_valid && !in_ready;
  assign out_valid       = (state == HOLD);
  assign mem_req         = (state == REQ);
  assign mem_err         = err;
  assign IR_out          = ir_p1;
  assign PC_out          = pc_p1;
  assign ALUOut          = z_p1;
  assign LMD             = lmd_p1;
  assign LMD_hi          = lmd_hi_p1;
  assign unused_addr_bit = addr_p1[0];

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    cnt_nxt    = cnt;
    err_nxt    = err;
    lmd_nxt    = lmd_p1;
    lmd_hi_nxt = lmd_hi_p1;
    take       = 1'b0;
    case (state)
      IDLE: take = in_valid;
      REQ: begin
        if (mem_ack) begin
          if (op == OP_LH)             lmd_nxt    = half_sext(mem_rdata, addr_p1[1]);
          else if (is_load(op) && beat) lmd_hi_nxt = mem_rdata;
          else if (is_load(op))        lmd_nxt    = mem_rdata;
          if (is_two(op) && !beat) begin
            beat_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            state_nxt = HOLD;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          // Abandon the access: flag it and hand zeroed load data downstream.
          err_nxt = 1'b1;
          if (is_load(op)) begin
            lmd_nxt    = '0;
            lmd_hi_nxt = '0;
          end
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          take = in_valid;
          if (!in_valid) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      state_nxt = (is_load(op_in) || is_store(op_in)) ? REQ : HOLD;
      beat_nxt  = 1'b0;
      cnt_nxt   = '0;
    end
  end

  // Stage boundary: execute -> memory registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      ir_p1     <= '0;
      pc_p1     <= '0;
      z_p1      <= '0;
      addr_p1   <= '0;
      lmd_p1    <= '0;
      lmd_hi_p1 <= '0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      cnt       <= cnt_nxt;
      err       <= err_nxt;
      lmd_p1    <= lmd_nxt;
      lmd_hi_p1 <= lmd_hi_nxt;
      if (take) begin
        ir_p1   <= IR_in;
        pc_p1   <= PC_in;
        z_p1    <= Z_in;
        addr_p1 <= Addr_in;
      end
    end
  end

  assign word_addr = {addr_p1[WIDTH-1:2], 2'b00} + {{(WIDTH-3){1'b0}}, beat, 2'b00};

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if (state == REQ) begin
      mem_we   = is_store(op);
      mem_addr = word_addr;
      mem_be   = !is_half(op) ? 4'b1111 : (addr_p1[1] ? 4'b1100 : 4'b0011);
      if (op == OP_SH)              mem_wdata = WIDTH'({z_p1[15:0], z_p1[15:0]});
      else if ((op == OP_SD) && beat) mem_wdata = '0;
      else if (is_store(op))         mem_wdata = z_p1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table vectors, hand-written multi-cycle sequences and random
// operations checked against a transaction-level model of loads and stores.
module tb_mem_stage;
  localparam int TO = 4;
  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LD  = 6'h37;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SD  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR_in = '0, Z_in = '0, Addr_in = '0, mem_rdata = '0;
  logic [29:0] PC_in = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0, mem_ack = 1'b0;
  logic        in_ready, out_valid, mem_req, mem_we, IsStall, mem_err;
  logic [31:0] IR_out, ALUOut, LMD, LMD_hi, mem_addr, mem_wdata;
  logic [29:0] PC_out;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .IR_in(IR_in), .PC_in(PC_in), .Z_in(Z_in), .Addr_in(Addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .IR_out(IR_out), .PC_out(PC_out),
    .ALUOut(ALUOut), .LMD(LMD), .LMD_hi(LMD_hi), .out_valid(out_valid), .out_ready(out_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .IsStall(IsStall),
    .mem_err(mem_err)
  );

  int errors = 0;
  int checks = 0;

  // Model state that survives between operations
  logic [31:0] exp_lmd = '0, exp_hi = '0;
  logic        exp_err = 1'b0;
  logic [31:0] seen_a0, seen_a1, seen_wd0, seen_wd1;
  logic [3:0]  seen_be;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr, z;
    int          d0, d1;
    logic [31:0] r0, r1;
    logic [31:0] a0, a1;
    logic [3:0]  be;
    logic [31:0] wd0, wd1, lmd, hi;
  } vec_t;

  vec_t       vt [8];
  logic [5:0] ops [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LH, OP_LD};
  endfunction

  function automatic bit m_store(input logic [5:0] op);
    return op inside {OP_SW, OP_SH, OP_SD};
  endfunction

  function automatic logic [31:0] load_value(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] half;
    if (op != OP_LH) return rd;
    half = (addr % 4 >= 2) ? rd / 65536 : rd % 65536;
    return (half >= 32768) ? half + 32'hFFFF0000 : half;
  endfunction

  function automatic void model_beat(input logic [5:0] op, input logic [31:0] addr,
                                     input logic [31:0] z, input int beat,
                                     output logic [31:0] a, output logic [3:0] be,
                                     output logic we, output logic [31:0] wd);
    a  = (addr - addr % 4) + 32'(4 * beat);
    we = m_store(op);
    if (op == OP_LH || op == OP_SH) be = (addr % 4 >= 2) ? 4'b1100 : 4'b0011;
    else be = 4'b1111;
    if (!we) wd = '0;
    else if (op == OP_SH) wd = (z % 65536) * 32'h10001;
    else if (op == OP_SD && beat == 1) wd = '0;
    else wd = z;
  endfunction

  // Issue one instruction from IDLE, act as memory, check beats and the writeback result.
  task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] z,
                       input int d0, input int d1, input logic [31:0] r0, input logic [31:0] r1);
    logic [31:0] ir, ea, ewd, r;
    logic [29:0] pc;
    logic [3:0]  ebe;
    logic        ewe;
    int          nb, d;
    bit          timed_out;
    ir = {op, 26'($urandom)};
    pc = 30'($urandom);
    seen_a0 = '0; seen_a1 = '0; seen_wd0 = '0; seen_wd1 = '0; seen_be = '0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    IR_in = ir; PC_in = pc; Z_in = z; Addr_in = addr; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    IR_in = $urandom; Z_in = $urandom; Addr_in = $urandom;
    nb = (op == OP_LD || op == OP_SD) ? 2 : ((m_load(op) || m_store(op)) ? 1 : 0);
    timed_out = 1'b0;
    for (int b = 0; b < nb; b++) begin
      model_beat(op, addr, z, b, ea, ebe, ewe, ewd);
      if (b == 0) begin seen_a0 = mem_addr; seen_wd0 = mem_wdata; seen_be = mem_be; end
      else begin seen_a1 = mem_addr; seen_wd1 = mem_wdata; end
      check("beat_req", 32'(mem_req), 32'd1);
      check("beat_addr", mem_addr, ea);
      check("beat_be", 32'(mem_be), 32'(ebe));
      check("beat_we", 32'(mem_we), 32'(ewe));
      check("beat_wdata", mem_wdata, ewd);
      check("beat_no_out_valid", 32'(out_valid), 32'd0);
      d = (b == 0) ? d0 : d1;
      r = (b == 0) ? r0 : r1;
      for (int k = 0; k < TO; k++) begin
        if (k == d) begin mem_ack = 1'b1; mem_rdata = r; end
        else begin mem_ack = 1'b0; mem_rdata = $urandom; end
        @(negedge clk);
        mem_ack = 1'b0;
        if (k == d) break;
        if (k == TO - 1) timed_out = 1'b1;
        else begin
          check("wait_req_held", 32'(mem_req), 32'd1);
          check("wait_addr_stable", mem_addr, ea);
        end
      end
      if (timed_out) begin
        exp_err = 1'b1;
        if (m_load(op)) begin exp_lmd = '0; exp_hi = '0; end
        break;
      end
      if (op == OP_LD && b == 1) exp_hi = r;
      else if (m_load(op)) exp_lmd = load_value(op, addr, r);
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("req_dropped", 32'(mem_req), 32'd0);
    check("IR_out", IR_out, ir);
    check("PC_out", 32'(PC_out), 32'(pc));
    check("ALUOut", ALUOut, z);
    check("LMD", LMD, exp_lmd);
    check("LMD_hi", LMD_hi, exp_hi);
    check("mem_err", 32'(mem_err), 32'(exp_err));
    @(negedge clk);
    check("out_valid_pulse", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ir_a, ir_l;
    vt[0] = '{OP_LW, 32'h104, 32'h0, 3, 0, 32'hDEADBEEF, 32'h0,
              32'h104, 32'h0, 4'hF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    vt[1] = '{OP_LH, 32'h102, 32'h0, 0, 0, 32'h80011234, 32'h0,
              32'h100, 32'h0, 4'hC, 32'h0, 32'h0, 32'hFFFF8001, 32'h0};
    vt[2] = '{OP_LH, 32'h200, 32'h0, 1, 0, 32'h80011234, 32'h0,
              32'h200, 32'h0, 4'h3, 32'h0, 32'h0, 32'h00001234, 32'h0};
    vt[3] = '{OP_SD, 32'hFFFFFFFC, 32'h55, 0, 2, 32'h0, 32'h0,
              32'hFFFFFFFC, 32'h0, 4'hF, 32'h55, 32'h0, 32'h00001234, 32'h0};
    vt[4] = '{OP_SH, 32'h1002, 32'h1234ABCD, 2, 0, 32'h0, 32'h0,
              32'h1000, 32'h0, 4'hC, 32'hABCDABCD, 32'h0, 32'h00001234, 32'h0};
    vt[5] = '{OP_LD, 32'h13, 32'h0, 2, 0, 32'h11111111, 32'h22222222,
              32'h10, 32'h14, 4'hF, 32'h0, 32'h0, 32'h11111111, 32'h22222222};
    vt[6] = '{OP_ADD, 32'h0, 32'h77, 0, 0, 32'h0, 32'h0,
              32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h11111111, 32'h22222222};
    vt[7] = '{OP_SW, 32'h2001, 32'hCAFEF00D, 1, 0, 32'h0, 32'h0,
              32'h2000, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, 32'h11111111, 32'h22222222};
    ops = '{OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD, OP_ADD, OP_NOP, OP_BEQ};

    // Reset values
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_IR_out", IR_out, 32'h0);
    check("rst_LMD", LMD, 32'h0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].op, vt[i].addr, vt[i].z, vt[i].d0, vt[i].d1, vt[i].r0, vt[i].r1);
      check($sformatf("vec%0d_a0", i), seen_a0, vt[i].a0);
      check($sformatf("vec%0d_a1", i), seen_a1, vt[i].a1);
      check($sformatf("vec%0d_be", i), 32'(seen_be), 32'(vt[i].be));
      check($sformatf("vec%0d_wd0", i), seen_wd0, vt[i].wd0);
      check($sformatf("vec%0d_wd1", i), seen_wd1, vt[i].wd1);
      check($sformatf("vec%0d_lmd", i), LMD, vt[i].lmd);
      check($sformatf("vec%0d_lmd_hi", i), LMD_hi, vt[i].hi);
    end

    // A stray ack with no request outstanding must not disturb anything
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_lmd", LMD, exp_lmd);
    check("stray_ack_req", 32'(mem_req), 32'd0);
    check("stray_ack_valid", 32'(out_valid), 32'd0);

    // ADD held by writeback backpressure while a LW waits upstream
    ir_a = {OP_ADD, 26'h0000123};
    IR_in = ir_a; Z_in = 32'h0A0A; PC_in = 30'h10; Addr_in = '0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    ir_l = {OP_LW, 26'h5};
    IR_in = ir_l; Addr_in = 32'h40; Z_in = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_IsStall", 32'(IsStall), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_IR_out", IR_out, ir_a);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_IsStall", 32'(IsStall), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lw_after_add_req", 32'(mem_req), 32'd1);
    check("lw_after_add_IR", IR_out, ir_l);
    check("lw_after_add_addr", mem_addr, 32'h40);
    mem_ack = 1'b1; mem_rdata = 32'h600DF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    exp_lmd = 32'h600DF00D;
    check("lw_after_add_valid", 32'(out_valid), 32'd1);
    check("lw_after_add_lmd", LMD, exp_lmd);
    @(negedge clk);

    // Random operations, acks always within the timeout window
    for (int i = 0; i < 40; i++) begin
      do_op(ops[$urandom_range(0, 8)], $urandom, $urandom,
            int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), $urandom, $urandom);
    end

    // Timeout on a load, then a store with the error still latched
    do_op(OP_LW, 32'h300, 32'h0, -1, 0, 32'h0, 32'h0);
    check("timeout_err", 32'(mem_err), 32'd1);
    check("timeout_lmd", LMD, 32'h0);
    do_op(OP_SW, 32'h304, 32'h1357, 0, 0, 32'h0, 32'h0);
    check("err_sticky", 32'(mem_err), 32'd1);

    // Reset in the middle of LD beat 1
    IR_in = {OP_LD, 26'h0}; Addr_in = 32'h80; Z_in = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ld_beat1_req", 32'(mem_req), 32'd1);
    check("ld_beat1_addr", mem_addr, 32'h84);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_lmd", LMD, 32'h0);
    check("midrst_err", 32'(mem_err), 32'd0);
    exp_lmd = '0; exp_hi = '0; exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_no_output", 32'(out_valid), 32'd0);
    do_op(OP_LW, 32'h88, 32'h0, 1, 0, 32'h0BADCAFE, 32'h0);
    check("post_rst_lw_lmd", LMD, 32'h0BADCAFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; opcode macros come from ISA.v.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles to wait for mem_ack per beat.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 IR_in  input  WIDTH  instruction from execute stage.
REQ-006 PC_in  input  WIDTH-2  word PC from execute stage.
REQ-007 Z_in  input  WIDTH  ALU result, or store data for stores.
REQ-008 Addr_in  input  WIDTH  effective byte address.
REQ-009 in_valid  input  1  upstream holds a valid instruction.
REQ-010 in_ready  output  1  stage can accept; transfer happens when in_valid and in_ready are both high.
REQ-011 IR_out  output  WIDTH  registered instruction to writeback.
REQ-012 PC_out  output  WIDTH-2  registered PC to writeback.
REQ-013 ALUOut  output  WIDTH  registered copy of Z_in.
REQ-014 LMD  output  WIDTH  load data, low word.
REQ-015 LMD_hi  output  WIDTH  load data, high word (LD only).
REQ-016 out_valid  output  1  outputs valid for writeback.
REQ-017 out_ready  input  1  writeback accepts outputs.
REQ-018 mem_req  output  1  data-memory request.
REQ-019 mem_we  output  1  write enable (1 = write).
REQ-020 mem_addr  output  WIDTH  word-aligned byte address.
REQ-021 mem_wdata  output  WIDTH  write data.
REQ-022 mem_be  output  4  byte enables.
REQ-023 mem_rdata  input  WIDTH  read data; valid only in the cycle mem_ack is high.
REQ-024 mem_ack  input  1  one-cycle completion pulse for the current beat.
REQ-025 IsStall  output  1  high while in_valid is high and in_ready is low.
REQ-026 mem_err  output  1  sticky timeout flag.

Function
REQ-027 FSM states are IDLE, REQ, HOLD; an accepted transfer latches IR/PC/Z/Addr into internal registers.
REQ-028 Transitions on an accepted transfer:
- LW/LH/LD/SW/SH/SD: IDLE->REQ, beat=0.
- Any other opcode (NOP/HALT/ALU/branch): IDLE->HOLD directly; LMD unchanged.
REQ-029 In REQ, mem_req stays high and address/data/enables stay stable until mem_ack.
REQ-030 mem_addr is {Addr[WIDTH-1:2],2'b00} for beat 0 and that value +4 for beat 1, wrapping modulo 2^WIDTH.
REQ-031 Byte enables:
- LW/SW: mem_be=4'b1111.
- LH/SH: mem_be=4'b0011 if Addr[1]=0, else 4'b1100.
- LD/SD: 4'b1111 on both beats.
REQ-032 LH result = selected halfword, sign-extended into LMD.
REQ-033 SH write data = Z[15:0] replicated into both halves of mem_wdata.
REQ-034 SD write data = Z on beat 0 and 0 on beat 1; LD loads beat 0 into LMD and beat 1 into LMD_hi.
REQ-035 On mem_ack, a two-beat op still at beat 0 advances to beat 1 and stays in REQ; otherwise REQ->HOLD.
REQ-036 mem_req drops in the cycle after mem_ack; mem_ack arriving while mem_req is low is ignored.
REQ-037 A per-beat counter clears on entry to each beat.
REQ-038 Timeout: if the counter reaches TIMEOUT without mem_ack:
- set mem_err;
- LMD/LMD_hi = 0 for loads;
- go REQ->HOLD.
REQ-039 mem_err clears only on reset.
REQ-040 In HOLD, out_valid=1. When out_ready=1:
- if in_valid=1: accept the new input in the same cycle (HOLD->REQ or HOLD->HOLD);
- otherwise: HOLD->IDLE.
REQ-041 in_ready = (state==IDLE) or (state==HOLD and out_ready).
REQ-042 Latency with immediate mem_ack: accept in cycle 0, mem_req in cycle 1, out_valid in cycle 2 (+1 cycle per extra beat); non-memory ops give out_valid in cycle 1.
REQ-043 Misaligned LW/SW/LD/SD (Addr[1:0]≠0): the low bits are ignored; no error is raised.

Reset
REQ-044 When rst_n is low, regardless of clk, the following are forced low/zero: state IDLE, out_valid, mem_req, mem_we, mem_err, mem_be, counters, IR_out, PC_out, ALUOut, LMD, LMD_hi, mem_addr, mem_wdata.
REQ-045 Reset asserted mid-access abandons the access; mem_req is low in the same cycle and no output is produced for that instruction.
REQ-046 After rst_n rises, in_ready is 1 on the first edge.

Verification
REQ-047 LW, Addr=0x104, ack after 3 cycles, rdata=0xDEADBEEF -> mem_addr=0x104, be=1111, we=0; LMD=0xDEADBEEF; out_valid 1 cycle after ack.
REQ-048 LH, Addr=0x102, rdata=0x8001_1234 -> be=1100; LMD=0xFFFF8001.
REQ-049 SD, Addr=0xFFFFFFFC, Z=0x55 -> beat 0 addr=0xFFFFFFFC wdata=0x55; beat 1 addr=0x0 wdata=0; we=1 on both beats.
REQ-050 LW with mem_ack never asserted, TIMEOUT=4 -> mem_err=1 after 4 REQ cycles; LMD=0; out_valid=1.
REQ-051 Back-to-back ADD then LW with out_ready held low 2 cycles -> IsStall=1 for those cycles; IR_out stays ADD; LW accepted in the cycle out_ready rises.
REQ-052 rst_n pulsed low during LD beat 1 -> mem_req=0 and out_valid=0 immediately; next LW executes normally.
